gpio_input_debounce: RTL and testbench

//   Conditions the per-pin read path between the pad IOBUF outputs (O) and the
//   SoC GPIO pins_read input. Each pin gets a synchronizer, a shared sample

---
 rtl/gpio_input_debounce.sv | 95 +++++++++
 tb/tb_gpio_input_debounce.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/gpio_input_debounce.sv
// GPIO read-path conditioning: per-pin synchronizer, shared sample prescaler,
// per-pin debounce counter and registered rise/fall pulses; driven pins bypass the debounce.
module gpio_input_debounce #(
    parameter int unsigned     WIDTH            = 4,
    parameter int unsigned     SYNC_STAGES      = 2,
    parameter int unsigned     PRESCALE         = 1,
    parameter int unsigned     DEBOUNCE_SAMPLES = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             io_clock,
    input  logic             io_reset,
    input  logic [WIDTH-1:0] io_pins_raw,
    input  logic [WIDTH-1:0] io_pins_writeEnable,
    output logic [WIDTH-1:0] io_pins_read,
    output logic [WIDTH-1:0] io_pins_rise,
    output logic [WIDTH-1:0] io_pins_fall
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned CW = (DEBOUNCE_SAMPLES > 1) ? $clog2(DEBOUNCE_SAMPLES) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_SAMPLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic             tick;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] read_q, read_d;
    logic [WIDTH-1:0] rise_q, fall_q;

    always_ff @(posedge io_clock or posedge io_reset) begin
        if (io_reset) begin
            for (int k = 0; k < int'(SYNC_STAGES); k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= io_pins_raw;
            for (int k = 1; k < int'(SYNC_STAGES); k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s      = sync_q[SYNC_STAGES-1];
    assign tick   = (pcnt_q == PCNT_LAST);
    assign pcnt_d = tick ? '0 : pcnt_q + PW'(1);

    always_comb begin
        read_d = read_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = cnt_q[i];
            if (io_pins_writeEnable[i]) begin
                read_d[i] = s[i];
                cnt_d[i]  = '0;
            end else if (tick) begin
                if (s[i] == read_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    read_d[i] = s[i];
                    cnt_d[i]  = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Pulses are derived from the next value so they appear together with it.
    always_ff @(posedge io_clock or posedge io_reset) begin
        if (io_reset) begin
            pcnt_q <= '0;
            read_q <= RESET_VALUE;
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            pcnt_q <= pcnt_d;
            read_q <= read_d;
            rise_q <= read_d & ~read_q;
            fall_q <= ~read_d & read_q;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign io_pins_read = read_q;
    assign io_pins_rise = rise_q;
    assign io_pins_fall = fall_q;

endmodule

// File: tb/tb_gpio_input_debounce.sv
// Directed bench for gpio_input_debounce: default build, a PRESCALE=8 build
// and a DEBOUNCE_SAMPLES=1 build sharing one clock and reset.
module tb_gpio_input_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] raw, we, rd, rise, fall;
    logic [3:0] raw_b, rd_b, rise_b, fall_b;
    logic [3:0] raw_c, rd_c, rise_c, fall_c;
    int         n_total = 0;
    int         n_bad   = 0;

    always #5 clk = ~clk;

    gpio_input_debounce dut (
        .io_clock(clk), .io_reset(rst), .io_pins_raw(raw), .io_pins_writeEnable(we),
        .io_pins_read(rd), .io_pins_rise(rise), .io_pins_fall(fall)
    );

    gpio_input_debounce #(.PRESCALE(8)) dut_b (
        .io_clock(clk), .io_reset(rst), .io_pins_raw(raw_b), .io_pins_writeEnable(4'h0),
        .io_pins_read(rd_b), .io_pins_rise(rise_b), .io_pins_fall(fall_b)
    );

    gpio_input_debounce #(.DEBOUNCE_SAMPLES(1)) dut_c (
        .io_clock(clk), .io_reset(rst), .io_pins_raw(raw_c), .io_pins_writeEnable(4'h0),
        .io_pins_read(rd_c), .io_pins_rise(rise_c), .io_pins_fall(fall_c)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reset with all raw inputs low, then leave 3 edges after release.
    task automatic do_reset();
        raw = 4'h0; raw_b = 4'h0; raw_c = 4'h0; we = 4'h0;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(3);
    endtask

    int   found;
    logic seen;

    initial begin
        // 1: reset with all pins high
        raw = 4'hF; we = 4'h0; raw_b = 4'h0; raw_c = 4'h0;
        rst = 1'b1;
        step(2);
        check_eq("rst_read", rd, 4'h0);
        check_eq("rst_rise", rise, 4'h0);
        check_eq("rst_fall", fall, 4'h0);
        rst = 1'b0;
        step(5);
        check_eq("t1_read_e5", rd, 4'h0);
        step(1);
        check_eq("t1_read_e6", rd, 4'hF);
        check_eq("t1_rise_e6", rise, 4'hF);
        step(1);
        check_eq("t1_rise_e7", rise, 4'h0);

        // 2: single pin qualified change
        do_reset();
        raw = 4'h1;
        step(5);
        check_eq("t2_read_e5", rd, 4'h0);
        step(1);
        check_eq("t2_read_e6", rd, 4'h1);
        check_eq("t2_rise_e6", rise, 4'h1);
        step(1);
        check_eq("t2_rise_e7", rise, 4'h0);
        check_eq("t2_fall_e7", fall, 4'h0);

        // 3: 3-cycle glitch on pin 1 is discarded
        raw = 4'h3;
        step(3);
        raw = 4'h1;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step(1);
            if (rd[1] || rise[1] || fall[1]) seen = 1'b1;
        end
        check_eq("t3_glitch", {31'd0, seen}, 32'd0);
        check_eq("t3_read", rd, 4'h1);

        // 4: bypass on pin 2 follows raw at edge 3
        we = 4'h4;
        raw = 4'h5;
        step(2);
        check_eq("t4_read_e2", rd, 4'h1);
        step(1);
        check_eq("t4_read_up", rd, 4'h5);
        check_eq("t4_rise", rise, 4'h4);
        step(1);
        check_eq("t4_rise_clr", rise, 4'h0);
        raw = 4'h1;
        step(3);
        check_eq("t4_read_dn", rd, 4'h1);
        check_eq("t4_fall", fall, 4'h4);
        step(1);
        check_eq("t4_fall_clr", fall, 4'h0);
        we = 4'h0;

        // DEBOUNCE_SAMPLES=1 accepts on the first mismatching tick
        raw_c = 4'h2;
        step(2);
        check_eq("ds1_read_e2", rd_c, 4'h0);
        step(1);
        check_eq("ds1_read_e3", rd_c, 4'h2);
        check_eq("ds1_rise_e3", rise_c, 4'h2);

        // 5: PRESCALE=8; ticks at release edges 8,16,..; change after edge 6 -> read at 34
        do_reset();
        step(3);
        raw_b = 4'h8;
        found = 0;
        for (int k = 1; k <= 50 && found == 0; k++) begin
            step(1);
            if (rd_b[3]) begin
                found = k;
                check_eq("t5_rise", rise_b, 4'h8);
            end
        end
        check_eq("t5_latency", found, 34);
        raw_b = 4'h0;
        step(45);
        check_eq("t5_back_low", rd_b, 4'h0);
        raw_b = 4'h8;
        step(16);
        raw_b = 4'h0;
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            step(1);
            if (rd_b[3] || rise_b[3]) seen = 1'b1;
        end
        check_eq("t5_pulse16", {31'd0, seen}, 32'd0);

        // 6: reset mid-count, then full re-qualification
        do_reset();
        raw = 4'h1;
        step(4);
        rst = 1'b1;
        #1;
        check_eq("t6_in_rst", rd, 4'h0);
        step(2);
        rst = 1'b0;
        step(5);
        check_eq("t6_read_e5", rd, 4'h0);
        step(1);
        check_eq("t6_read_e6", rd, 4'h1);
        check_eq("t6_rise_e6", rise, 4'h1);
        // asynchronous clear between edges
        #3;
        rst = 1'b1;
        #1;
        check_eq("t6_async_read", rd, 4'h0);
        check_eq("t6_async_rise", rise, 4'h0);
        #1;
        rst = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
